// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch block.
//   - fetch_state_e    : fetch FSM state encoding
//   - OP_RTYPE         : R-type primary opcode (JR lives under it)
//   - DEF_OP_JR_FUNCT  : default Funct code that marks JR
//   - OP_J / OP_JAL    : jump primary opcodes
//   - DEF_RESET_VECTOR : default first fetch address after reset
//   - branch_offset()  : sign-extended, word-scaled branch displacement
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  localparam logic [5:0]  OP_RTYPE         = 6'b000000;
  localparam logic [5:0]  DEF_OP_JR_FUNCT  = 6'b001000;
  localparam logic [5:0]  OP_J             = 6'b000010;
  localparam logic [5:0]  OP_JAL           = 6'b000011;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;

  // Sign-extend a 16-bit immediate and scale it to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection for the held instruction.
// Ports:
//   pc4     in  32  PC+4 of the held instruction
//   instr   in  32  held instruction word
//   jump    in  1   control-unit Jump
//   branch  in  1   control-unit Branch (don't-care when jump=1)
//   zero    in  1   ALU zero flag
//   reg_rs  in  32  rs register value (JR target)
//   next_pc out 32  selected next fetch address
module next_pc_sel
  import inst_fetch_pkg::*;
#(
  parameter logic [5:0] OP_JR_FUNCT = DEF_OP_JR_FUNCT
) (
  input  logic [31:0] pc4,
  input  logic [31:0] instr,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] reg_rs,
  output logic [31:0] next_pc
);

  logic is_jr_s;

  assign is_jr_s = (instr[31:26] == OP_RTYPE) && (instr[5:0] == OP_JR_FUNCT);

  // Priority select: JR, then J/JAL, then taken branch, then fall-through.
  // Branch is only looked at when jump=0 because it may be undefined otherwise.
  always_comb begin
    next_pc = pc4;
    if (jump == 1'b1) begin
      if (is_jr_s) begin
        next_pc = reg_rs;
      end else begin
        next_pc = {pc4[31:28], instr[25:0], 2'b00};
      end
    end else if ((branch == 1'b1) && (zero == 1'b1)) begin
      next_pc = pc4 + branch_offset(instr[15:0]);
    end else begin
      next_pc = pc4;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch unit: holds PC, issues one memory request at a time,
// registers the returned instruction and advances PC when downstream
// accepts it. A misaligned next-PC halts fetching with a sticky AddrErr.
// Ports:
//   Clock, ResetN        clock, async active-low reset
//   IMemReq/IMemAddr     fetch request and address (= PC)
//   IMemReady/IMemData   memory response
//   Instr/Opcode/Funct   held instruction and its decode fields
//   InstrValid           Instr holds an unconsumed instruction
//   InstrAccept          downstream consumes Instr; next-PC inputs valid
//   PC4                  PC+4 of the held instruction
//   Jump/Branch/JR_JAL   control-unit outputs for the held instruction
//   Zero                 ALU zero flag
//   RegRs                JR target
//   AddrErr              sticky misaligned-target flag
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [5:0]  OP_JR_FUNCT  = DEF_OP_JR_FUNCT
) (
  input  logic        Clock,
  input  logic        ResetN,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Instr,
  output logic [5:0]  Opcode,
  output logic [5:0]  Funct,
  output logic        InstrValid,
  input  logic        InstrAccept,
  output logic [31:0] PC4,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        JR_JAL,
  input  logic        Zero,
  input  logic [31:0] RegRs,
  output logic        AddrErr
);

  fetch_state_e state_r;
  fetch_state_e state_nxt_s;
  logic [31:0]  pc_r;
  logic [31:0]  pc4_r;
  logic [31:0]  instr_r;
  logic         req_r;
  logic         valid_r;
  logic         err_r;
  logic [31:0]  next_pc_s;
  logic         load_instr_s;
  logic         load_pc_s;
  logic         set_err_s;
  logic         unused_s;

  // JR is recognised from Opcode/Funct, so the JR_JAL hint is not needed here.
  assign unused_s = JR_JAL;

  next_pc_sel #(
    .OP_JR_FUNCT (OP_JR_FUNCT)
  ) u_next_pc_sel (
    .pc4     (pc4_r),
    .instr   (instr_r),
    .jump    (Jump),
    .branch  (Branch),
    .zero    (Zero),
    .reg_rs  (RegRs),
    .next_pc (next_pc_s)
  );

  // Next-state and load-enable decode for the fetch FSM.
  always_comb begin
    state_nxt_s  = state_r;
    load_instr_s = 1'b0;
    load_pc_s    = 1'b0;
    set_err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_REQ;
      end
      ST_REQ: begin
        if (IMemReady == 1'b1) begin
          state_nxt_s  = ST_HOLD;
          load_instr_s = 1'b1;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (InstrAccept == 1'b1) begin
          // A misaligned target halts without touching PC.
          if (next_pc_s[1:0] != 2'b00) begin
            state_nxt_s = ST_HALT;
            set_err_s   = 1'b1;
          end else begin
            state_nxt_s = ST_REQ;
            load_pc_s   = 1'b1;
          end
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state plus request/valid flags registered from the next state.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_r <= ST_IDLE;
      req_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      req_r   <= (state_nxt_s == ST_REQ);
      valid_r <= (state_nxt_s == ST_HOLD);
    end
  end

  // PC and its +4 companion; PC4 is kept registered so it tracks PC exactly.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      pc_r  <= RESET_VECTOR;
      pc4_r <= RESET_VECTOR + 32'd4;
    end else if (load_pc_s) begin
      pc_r  <= next_pc_s;
      pc4_r <= next_pc_s + 32'd4;
    end else begin
      pc_r  <= pc_r;
      pc4_r <= pc4_r;
    end
  end

  // Instruction register, loaded only on a completed memory response.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      instr_r <= 32'h0000_0000;
    end else if (load_instr_s) begin
      instr_r <= IMemData;
    end else begin
      instr_r <= instr_r;
    end
  end

  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      err_r <= 1'b0;
    end else if (set_err_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign IMemReq    = req_r;
  assign IMemAddr   = pc_r;
  assign Instr      = instr_r;
  assign Opcode     = instr_r[31:26];
  assign Funct      = instr_r[5:0];
  assign InstrValid = valid_r;
  assign PC4        = pc4_r;
  assign AddrErr    = err_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized self-checking bench for inst_fetch with a transaction-level
// reference model (expected PC / held instruction / halt flag).
module tb_inst_fetch;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        Clock;
  logic        ResetN;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic [31:0] Instr;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic        InstrValid;
  logic        InstrAccept;
  logic [31:0] PC4;
  logic        Jump;
  logic        Branch;
  logic        JR_JAL;
  logic        Zero;
  logic [31:0] RegRs;
  logic        AddrErr;

  int total;
  int bad;

  logic [31:0] pc_m;
  logic [31:0] instr_m;
  logic        halted_m;

  inst_fetch dut (
    .Clock       (Clock),
    .ResetN      (ResetN),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemReady   (IMemReady),
    .IMemData    (IMemData),
    .Instr       (Instr),
    .Opcode      (Opcode),
    .Funct       (Funct),
    .InstrValid  (InstrValid),
    .InstrAccept (InstrAccept),
    .PC4         (PC4),
    .Jump        (Jump),
    .Branch      (Branch),
    .JR_JAL      (JR_JAL),
    .Zero        (Zero),
    .RegRs       (RegRs),
    .AddrErr     (AddrErr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference next-PC, straight from the architectural rules.
  function automatic logic [31:0] model_next(input logic [31:0] ins, input logic [31:0] pc,
                                             input logic j, input logic b, input logic z,
                                             input logic [31:0] rs);
    logic [31:0] p4;
    int          off;
    p4 = pc + 32'd4;
    if (j && ins[31:26] == 6'd0 && ins[5:0] == 6'd8) return rs;
    if (j) return {p4[31:28], ins[25:0], 2'b00};
    if (b && z) begin
      off = int'($signed(ins[15:0])) * 4;
      return p4 + 32'(off);
    end
    return p4;
  endfunction

  // Reset, check cleared outputs, release; ends at a negedge with DUT in REQ.
  task automatic do_reset();
    IMemReady   = 1'b0;
    InstrAccept = 1'b0;
    @(negedge Clock);
    ResetN = 1'b0;
    #1;
    check_val("rst_req",   {31'd0, IMemReq},    32'd0);
    check_val("rst_valid", {31'd0, InstrValid}, 32'd0);
    check_val("rst_err",   {31'd0, AddrErr},    32'd0);
    check_val("rst_instr", Instr,               32'd0);
    check_val("rst_addr",  IMemAddr,            RV);
    @(negedge Clock);
    ResetN = 1'b1;
    @(negedge Clock);
    pc_m     = RV;
    halted_m = 1'b0;
    check_val("rel_req",  {31'd0, IMemReq}, 32'd1);
    check_val("rel_addr", IMemAddr,         RV);
  endtask

  // Serve one fetch after 'waits' not-ready cycles; ends with DUT in HOLD.
  task automatic fetch_one(input int waits, input logic [31:0] data);
    for (int i = 0; i < waits; i++) begin
      IMemReady = 1'b0;
      IMemData  = $urandom;
      check_val("wait_req",   {31'd0, IMemReq},    32'd1);
      check_val("wait_addr",  IMemAddr,            pc_m);
      check_val("wait_valid", {31'd0, InstrValid}, 32'd0);
      @(negedge Clock);
    end
    IMemReady = 1'b1;
    IMemData  = data;
    check_val("req_addr", IMemAddr,         pc_m);
    check_val("req_req",  {31'd0, IMemReq}, 32'd1);
    @(negedge Clock);
    IMemReady = 1'b0;
    IMemData  = $urandom;
    instr_m   = data;
    check_val("got_valid", {31'd0, InstrValid}, 32'd1);
    check_val("got_req",   {31'd0, IMemReq},    32'd0);
    check_val("got_instr", Instr,               data);
    check_val("got_op",    {26'd0, Opcode},     {26'd0, data[31:26]});
    check_val("got_funct", {26'd0, Funct},      {26'd0, data[5:0]});
    check_val("got_pc4",   PC4,                 pc_m + 32'd4);
  endtask

  // Hold for 'holds' cycles, then accept with the given control inputs.
  task automatic hold_accept(input int holds, input logic j, input logic b, input logic z,
                             input logic [31:0] rs);
    logic [31:0] nxt;
    for (int i = 0; i < holds; i++) begin
      InstrAccept = 1'b0;
      Jump = $urandom_range(0, 1); Branch = $urandom_range(0, 1); Zero = $urandom_range(0, 1);
      IMemReady = $urandom_range(0, 1);
      @(negedge Clock);
      check_val("hold_valid", {31'd0, InstrValid}, 32'd1);
      check_val("hold_instr", Instr,               instr_m);
      check_val("hold_addr",  IMemAddr,            pc_m);
    end
    IMemReady   = 1'b0;
    InstrAccept = 1'b1;
    Jump = j; Branch = b; Zero = z; RegRs = rs;
    JR_JAL = $urandom_range(0, 1);
    nxt = model_next(instr_m, pc_m, j, b, z, rs);
    @(negedge Clock);
    InstrAccept = 1'b0;
    if (nxt[1:0] != 2'b00) begin
      halted_m = 1'b1;
      check_val("halt_err", {31'd0, AddrErr}, 32'd1);
      check_val("halt_pc",  IMemAddr,         pc_m);
    end else begin
      pc_m = nxt;
      check_val("acc_err",  {31'd0, AddrErr}, 32'd0);
      check_val("acc_addr", IMemAddr,         pc_m);
    end
    check_val("acc_req",   {31'd0, IMemReq},    {31'd0, ~halted_m});
    check_val("acc_valid", {31'd0, InstrValid}, 32'd0);
  endtask

  // Stay in HALT a few cycles with memory poking; nothing should move.
  task automatic check_halt(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      IMemReady   = 1'b1;
      InstrAccept = $urandom_range(0, 1);
      @(negedge Clock);
      check_val("halt_req",   {31'd0, IMemReq},    32'd0);
      check_val("halt_valid", {31'd0, InstrValid}, 32'd0);
      check_val("halt_stick", {31'd0, AddrErr},    32'd1);
    end
    IMemReady   = 1'b0;
    InstrAccept = 1'b0;
  endtask

  initial begin
    int          sel;
    logic [31:0] data;
    logic [31:0] rs;
    logic        j;
    logic        b;
    logic        z;
    total = 0; bad = 0;
    ResetN = 1'b0; IMemReady = 1'b0; IMemData = 32'd0; InstrAccept = 1'b0;
    Jump = 1'b0; Branch = 1'b0; JR_JAL = 1'b0; Zero = 1'b0; RegRs = 32'd0;
    pc_m = RV; instr_m = 32'd0; halted_m = 1'b0;
    @(negedge Clock);
    #1;
    check_val("init_req",   {31'd0, IMemReq},    32'd0);
    check_val("init_instr", Instr,               32'd0);
    check_val("init_valid", {31'd0, InstrValid}, 32'd0);

    // Ready already high at release: ignored in IDLE, taken in REQ.
    IMemReady = 1'b1;
    IMemData  = 32'h2008_0005;
    @(negedge Clock);
    ResetN = 1'b1;
    @(negedge Clock);
    check_val("first_req",  {31'd0, IMemReq},    32'd1);
    check_val("first_addr", IMemAddr,            32'd0);
    check_val("first_val0", {31'd0, InstrValid}, 32'd0);
    @(negedge Clock);
    IMemReady = 1'b0;
    check_val("first_valid", {31'd0, InstrValid}, 32'd1);
    check_val("first_instr", Instr,               32'h2008_0005);
    check_val("first_pc4",   PC4,                 32'd4);
    instr_m = 32'h2008_0005;
    hold_accept(2, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("seq_pc4", IMemAddr, 32'd4);

    fetch_one(0, 32'h0000_0020);
    hold_accept(0, 1'b0, 1'b0, 1'b1, 32'd0);
    check_val("pc_eq8", IMemAddr, 32'd8);

    // Slow memory, then BEQ with offset -1 from PC=8 loops back to 8.
    fetch_one(5, 32'h1000_FFFF);
    hold_accept(1, 1'b0, 1'b1, 1'b1, 32'd0);
    check_val("beq_back", IMemAddr, 32'd8);

    // J to 0x40.
    fetch_one(1, 32'h0800_0010);
    hold_accept(0, 1'b1, 1'b0, 1'b0, 32'd0);
    check_val("j_target", IMemAddr, 32'h40);

    // JR to the top word, then PC4 wraps.
    fetch_one(0, 32'h03E0_0008);
    hold_accept(0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    fetch_one(0, 32'h0000_0000);
    check_val("pc4_wrap", PC4, 32'd0);
    hold_accept(0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("wrap_addr", IMemAddr, 32'd0);

    // Misaligned JR target halts.
    fetch_one(0, 32'h03E0_0008);
    hold_accept(0, 1'b1, 1'b0, 1'b0, 32'h22);
    check_val("jr_halted", {31'd0, halted_m}, 32'd1);
    check_halt(3);

    // Reset in the middle of a request; responses during reset are ignored.
    do_reset();
    IMemReady = 1'b0;
    @(negedge Clock);
    #1;
    ResetN = 1'b0;
    #1;
    check_val("midrst_req", {31'd0, IMemReq}, 32'd0);
    IMemReady = 1'b1;
    IMemData  = 32'hDEAD_BEEF;
    repeat (3) @(negedge Clock);
    check_val("midrst_valid", {31'd0, InstrValid}, 32'd0);
    check_val("midrst_instr", Instr,               32'd0);
    IMemReady = 1'b0;
    ResetN    = 1'b1;
    @(negedge Clock);
    pc_m = RV;
    check_val("restart_addr",  IMemAddr,            RV);
    check_val("restart_req",   {31'd0, IMemReq},    32'd1);
    check_val("restart_valid", {31'd0, InstrValid}, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      sel  = $urandom_range(0, 3);
      data = $urandom;
      j = 1'b0; b = $urandom_range(0, 1); z = $urandom_range(0, 1);
      rs = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rs = $urandom;
      case (sel)
        0: begin data[31:26] = 6'b000010; j = 1'b1; end
        1: begin data[31:26] = 6'b000100; end
        2: begin data[31:26] = 6'b000000; data[5:0] = 6'b001000; j = 1'b1; end
        default: j = $urandom_range(0, 1);
      endcase
      fetch_one($urandom_range(0, 3), data);
      hold_accept($urandom_range(0, 2), j, b, z, rs);
      if (halted_m) begin
        check_halt(1);
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter OP_JR_FUNCT, default 6'b001000, the Funct code that marks JR when Opcode is 6'b000000.
REQ-003 Clock  in  1  single clock; all state changes on the rising edge.
REQ-004 ResetN  in  1  reset, asynchronous assert, active-low.
REQ-005 IMemReq  out  1  instruction-memory request, held until IMemReady.
REQ-006 IMemAddr  out  32  fetch address, equal to PC.
REQ-007 IMemReady  in  1  memory returns IMemData this cycle.
REQ-008 IMemData  in  32  instruction word.
REQ-009 Instr  out  32  registered instruction, stable while InstrValid.
REQ-010 Opcode  out  6  Instr[31:26], fed to the control unit.
REQ-011 Funct  out  6  Instr[5:0], fed to the control unit.
REQ-012 InstrValid  out  1  Instr holds an unconsumed instruction.
REQ-013 InstrAccept  in  1  downstream consumes Instr; next-PC inputs are valid this cycle.
REQ-014 PC4  out  32  PC+4 of the held instruction, for the JAL link.
REQ-015 Jump, Branch, JR_JAL  in  1 each  control-unit outputs for the held instruction.
REQ-016 Zero  in  1  ALU zero flag for BEQ.
REQ-017 RegRs  in  32  rs register value for the JR target.
REQ-018 AddrErr  out  1  sticky flag for a misaligned fetch target.

Function
REQ-019 The FSM SHALL have the states IDLE, REQ, HOLD and HALT.
REQ-020 IDLE SHALL go to REQ on the first clock after reset is released, with PC=RESET_VECTOR.
REQ-021 In REQ, IMemReq=1 and IMemAddr=PC SHALL hold steady until IMemReady=1.
REQ-022 When IMemReady=1 in REQ, Instr SHALL load IMemData on that edge and the FSM SHALL go to HOLD.
REQ-023 In HOLD, InstrValid=1, IMemReq=0, and Instr/PC SHALL not change.
REQ-024 In HOLD with InstrAccept=0, the FSM SHALL stay in HOLD indefinitely.
REQ-025 In HOLD with InstrAccept=1, PC SHALL load NextPC and the FSM SHALL go to REQ; fetch-to-fetch latency is 2 cycles minimum.
REQ-026 NextPC priority 1, JR (Opcode=0, Funct=OP_JR_FUNCT, Jump=1): NextPC=RegRs.
REQ-027 NextPC priority 2, J or JAL (Jump=1, not JR): NextPC={PC4[31:28],Instr[25:0],2'b00}.
REQ-028 NextPC priority 3, Branch=1 and Zero=1: NextPC=PC4+(sign-extended Instr[15:0]<<2), modulo 2^32.
REQ-029 NextPC priority 4, otherwise: NextPC=PC4.
REQ-030 Branch and JR_JAL SHALL be ignored when Jump=1, since they may be X.
REQ-031 PC4 SHALL equal PC+4 modulo 2^32; 32'hFFFF_FFFC SHALL wrap to 0.
REQ-032 On accept, if NextPC[1:0]!=0, the FSM SHALL go to HALT, set AddrErr=1, and leave PC unchanged.
REQ-033 HALT SHALL keep IMemReq=0 and InstrValid=0 until reset.

Reset
REQ-034 Asserting ResetN=0 SHALL immediately force the FSM to IDLE, PC=RESET_VECTOR, Instr=0, and IMemReq, InstrValid and AddrErr to 0, even mid-request.
REQ-035 A memory response that arrives during or after reset SHALL be ignored.

Structure
REQ-036 The shared package SHALL hold the state enum, the R-type opcode constant 6'b000000, OP_JR_FUNCT, the J/JAL opcodes, and the RESET_VECTOR default.
REQ-037 Next-PC selection SHALL be a combinational sub-module named next_pc_sel; all FSM and registers SHALL stay in inst_fetch.

Verification
REQ-038 Reset release with IMemReady=1 and data 32'h2008_0005 -> IMemAddr=0, Instr valid 1 cycle later, PC4=4.
REQ-039 IMemReady held low 5 cycles -> IMemReq and IMemAddr stable throughout, InstrValid=0.
REQ-040 Branch=1, Zero=1, Instr[15:0]=16'hFFFF, PC=8 -> next IMemAddr=8.
REQ-041 Instr=32'h0800_0010 with Jump=1 (J) -> IMemAddr=32'h40; JR with RegRs=32'h22 -> AddrErr=1, HALT.
REQ-042 ResetN low while in REQ -> IMemReq=0 in the same cycle; later IMemReady ignored, fetch restarts at RESET_VECTOR.
